branch_cond_unit: RTL and testbench

Parametrised successor to the ID-stage SPARC condition handler. Holds NUM_CC registered condition-code sets (NZVC), written by EX. Resolves Bicc-style branches in ID against a selected set. Tracks delay-slot execute/annul per SPARC annul-bit rules and keeps saturating taken/not-taken counters. Sits between EX flag writeback and ID/IF next-PC control.

---
 rtl/branch_cond_unit_pkg.sv | 31 +++
 rtl/branch_cond_unit_cond_eval.sv | 39 +++
 rtl/branch_cond_unit.sv | 137 +++++++++++++
 tb/tb_branch_cond_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the branch condition unit:
// SPARC cond codes, NZVC bit positions and delay-slot FSM encoding.
package branch_cond_unit_pkg;

    localparam logic [3:0] COND_BN   = 4'b0000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BLE  = 4'b0010;
    localparam logic [3:0] COND_BL   = 4'b0011;
    localparam logic [3:0] COND_BLEU = 4'b0100;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;
    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BNE  = 4'b1001;
    localparam logic [3:0] COND_BG   = 4'b1010;
    localparam logic [3:0] COND_BGE  = 4'b1011;
    localparam logic [3:0] COND_BGU  = 4'b1100;
    localparam logic [3:0] COND_BCC  = 4'b1101;
    localparam logic [3:0] COND_BPOS = 4'b1110;
    localparam logic [3:0] COND_BVC  = 4'b1111;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int V_BIT = 1;
    localparam int C_BIT = 0;

    localparam logic [1:0] ST_IDLE       = 2'b00;
    localparam logic [1:0] ST_SLOT_EXEC  = 2'b01;
    localparam logic [1:0] ST_SLOT_ANNUL = 2'b10;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// cond_eval: combinational SPARC condition test, flags + cond -> true.
// Ports: flags_i (NZVC), cond_i (4-bit cond field), true_o.
module cond_eval
    import branch_cond_unit_pkg::*;
(
    input  logic [3:0] flags_i,
    input  logic [3:0] cond_i,
    output logic       true_o
);

    logic n;
    logic z;
    logic v;
    logic c;
    logic base;

    assign n = flags_i[N_BIT];
    assign z = flags_i[Z_BIT];
    assign v = flags_i[V_BIT];
    assign c = flags_i[C_BIT];

    always_comb begin
        base = 1'b0;
        unique case (cond_i[2:0])
            3'b000: base = 1'b0;
            3'b001: base = z;
            3'b010: base = z | (n ^ v);
            3'b011: base = n ^ v;
            3'b100: base = c | z;
            3'b101: base = c;
            3'b110: base = n;
            3'b111: base = v;
        endcase
    end

    // Upper half of the encoding is the complement of the lower half.
    assign true_o = base ^ cond_i[3];

endmodule

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: NZVC sets, Bicc resolution, delay-slot annul FSM, stats.
// Ports: clk, rst_n, cc_we/cc_wsel/cc_wdata (EX flag write), br_valid/
// br_cond/br_annul/br_ccsel (ID branch), pipe_advance, flush;
// outputs branch_taken, cc_stall, annul_slot, in_delay_slot,
// taken_cnt, nottaken_cnt. Optional macro: CC_BYPASS_EN (EX->ID forward).
module branch_cond_unit
    import branch_cond_unit_pkg::*;
#(
    parameter int NUM_CC = 2,
    parameter int SEL_W  = (NUM_CC > 1) ? $clog2(NUM_CC) : 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cc_we,
    input  logic [SEL_W-1:0] cc_wsel,
    input  logic [3:0]       cc_wdata,
    input  logic             br_valid,
    input  logic [3:0]       br_cond,
    input  logic             br_annul,
    input  logic [SEL_W-1:0] br_ccsel,
    input  logic             pipe_advance,
    input  logic             flush,
    output logic             branch_taken,
    output logic             cc_stall,
    output logic             annul_slot,
    output logic             in_delay_slot,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nottaken_cnt
);

    logic [3:0]       cc_q [NUM_CC];
    logic [3:0]       cc_d [NUM_CC];
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] taken_q;
    logic [CNT_W-1:0] taken_d;
    logic [CNT_W-1:0] nt_q;
    logic [CNT_W-1:0] nt_d;

    logic [3:0] stored_flags;
    logic [3:0] eval_flags;
    logic       hz;
    logic       cond_true;
    logic       in_annul;
    logic       accept;

    // Selectors beyond NUM_CC match no set: writes drop, reads give 0.
    always_comb begin
        cc_d = cc_q;
        for (int i = 0; i < NUM_CC; i++) begin
            if (cc_we && (cc_wsel == SEL_W'(i))) begin
                cc_d[i] = cc_wdata;
            end
        end
    end

    always_comb begin
        stored_flags = 4'b0000;
        for (int i = 0; i < NUM_CC; i++) begin
            if (br_ccsel == SEL_W'(i)) begin
                stored_flags = cc_q[i];
            end
        end
    end

    assign hz = br_valid & cc_we & (cc_wsel == br_ccsel);

`ifdef CC_BYPASS_EN
    assign eval_flags = hz ? cc_wdata : stored_flags;
    assign cc_stall   = 1'b0;
`else
    assign eval_flags = stored_flags;
    assign cc_stall   = hz;
`endif

    cond_eval u_cond_eval (
        .flags_i (eval_flags),
        .cond_i  (br_cond),
        .true_o  (cond_true)
    );

    assign in_annul     = (state_q == ST_SLOT_ANNUL);
    assign branch_taken = br_valid & ~cc_stall & ~in_annul & cond_true;
    assign accept       = br_valid & pipe_advance & ~cc_stall & ~in_annul;

    // BA,a annuls its slot even though it is taken.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            if (br_annul && (!cond_true || br_cond == COND_BA)) begin
                state_d = ST_SLOT_ANNUL;
            end else begin
                state_d = ST_SLOT_EXEC;
            end
        end else if (pipe_advance && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    // Counters ignore flush and saturate at all-ones.
    always_comb begin
        taken_d = taken_q;
        nt_d    = nt_q;
        if (accept) begin
            if (cond_true) begin
                if (taken_q != '1) taken_d = taken_q + CNT_W'(1);
            end else begin
                if (nt_q != '1) nt_d = nt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CC; i++) begin
                cc_q[i] <= 4'b0000;
            end
            state_q <= ST_IDLE;
            taken_q <= '0;
            nt_q    <= '0;
        end else begin
            cc_q    <= cc_d;
            state_q <= state_d;
            taken_q <= taken_d;
            nt_q    <= nt_d;
        end
    end

    assign annul_slot    = in_annul;
    assign in_delay_slot = (state_q != ST_IDLE);
    assign taken_cnt     = taken_q;
    assign nottaken_cnt  = nt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit with a queue-based scoreboard.
// Small counters (CNT_W=2) make saturation reachable.
module tb_branch_cond_unit;

`ifdef CC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cc_we;
    logic [0:0] cc_wsel;
    logic [3:0] cc_wdata;
    logic       br_valid;
    logic [3:0] br_cond;
    logic       br_annul;
    logic [0:0] br_ccsel;
    logic       pipe_advance;
    logic       flush;
    logic       branch_taken;
    logic       cc_stall;
    logic       annul_slot;
    logic       in_delay_slot;
    logic [1:0] taken_cnt;
    logic [1:0] nottaken_cnt;

    branch_cond_unit #(.NUM_CC(2), .CNT_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cc_we         (cc_we),
        .cc_wsel       (cc_wsel),
        .cc_wdata      (cc_wdata),
        .br_valid      (br_valid),
        .br_cond       (br_cond),
        .br_annul      (br_annul),
        .br_ccsel      (br_ccsel),
        .pipe_advance  (pipe_advance),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .cc_stall      (cc_stall),
        .annul_slot    (annul_slot),
        .in_delay_slot (in_delay_slot),
        .taken_cnt     (taken_cnt),
        .nottaken_cnt  (nottaken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] v;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    event chk_ev;

    function automatic logic [7:0] E(bit tk, bit st, bit an, bit sl,
                                     int tc, int nt);
        return {tk, st, an, sl, 2'(tc), 2'(nt)};
    endfunction

    // Monitor: compares everything queued for the current cycle.
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                act = {branch_taken, cc_stall, annul_slot, in_delay_slot,
                       taken_cnt, nottaken_cnt};
                tests++;
                if (act !== e.v) begin
                    fails++;
                    $display("FAIL %s: got tk/st/an/sl/tc/nt=%b required %b",
                             e.name, act, e.v);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic we, input logic ws,
                       input logic [3:0] wd, input logic bv,
                       input logic [3:0] cd, input logic an,
                       input logic cs, input logic adv, input logic fl,
                       input logic [7:0] ex);
        exp_t e;
        @(posedge clk);
        #1;
        cc_we = we;
        cc_wsel = ws;
        cc_wdata = wd;
        br_valid = bv;
        br_cond = cd;
        br_annul = an;
        br_ccsel = cs;
        pipe_advance = adv;
        flush = fl;
        e.name = nm;
        e.v = ex;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        cc_we = 1'b0;
        cc_wsel = 1'b0;
        cc_wdata = 4'h0;
        br_valid = 1'b0;
        br_cond = 4'h0;
        br_annul = 1'b0;
        br_ccsel = 1'b0;
        pipe_advance = 1'b0;
        flush = 1'b0;

        // Writes during reset must not land.
        cyc("rst_w0", 1, 0, 4'hF, 0, 4'h0, 0, 0, 1, 0, E(0,0,0,0,0,0));
        cyc("rst_w1", 1, 1, 4'hF, 0, 4'h0, 0, 0, 1, 0, E(0,0,0,0,0,0));
        cyc("rst_idle", 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,0,0,0,0));
        rst_n = 1'b1;
        cyc("rst_be0", 0, 0, 4'h0, 1, 4'b0001, 0, 0, 0, 0, E(0,0,0,0,0,0));
        cyc("rst_bne1", 0, 0, 4'h0, 1, 4'b1001, 0, 1, 0, 0, E(1,0,0,0,0,0));

        // set1 = Z, then condition sweep without accepting.
        cyc("wr_set1", 1, 1, 4'b0100, 0, 4'h0, 0, 0, 0, 0, E(0,0,0,0,0,0));
        cyc("s1_be",   0, 0, 4'h0, 1, 4'b0001, 0, 1, 0, 0, E(1,0,0,0,0,0));
        cyc("s1_ble",  0, 0, 4'h0, 1, 4'b0010, 0, 1, 0, 0, E(1,0,0,0,0,0));
        cyc("s1_bleu", 0, 0, 4'h0, 1, 4'b0100, 0, 1, 0, 0, E(1,0,0,0,0,0));
        cyc("s1_bne",  0, 0, 4'h0, 1, 4'b1001, 0, 1, 0, 0, E(0,0,0,0,0,0));
        cyc("s1_bg",   0, 0, 4'h0, 1, 4'b1010, 0, 1, 0, 0, E(0,0,0,0,0,0));
        cyc("s0_be",   0, 0, 4'h0, 1, 4'b0001, 0, 0, 0, 0, E(0,0,0,0,0,0));
        cyc("s0_ble",  0, 0, 4'h0, 1, 4'b0010, 0, 0, 0, 0, E(0,0,0,0,0,0));
        cyc("s0_bleu", 0, 0, 4'h0, 1, 4'b0100, 0, 0, 0, 0, E(0,0,0,0,0,0));
        cyc("s0_bne",  0, 0, 4'h0, 1, 4'b1001, 0, 0, 0, 0, E(1,0,0,0,0,0));
        cyc("s0_bg",   0, 0, 4'h0, 1, 4'b1010, 0, 0, 0, 0, E(1,0,0,0,0,0));
        cyc("s0_ba",   0, 0, 4'h0, 1, 4'b1000, 0, 0, 0, 0, E(1,0,0,0,0,0));
        cyc("s0_bn",   0, 0, 4'h0, 1, 4'b0000, 0, 0, 0, 0, E(0,0,0,0,0,0));

        // Annul rules.
        cyc("ba_a",    0, 0, 4'h0, 1, 4'b1000, 1, 0, 1, 0, E(1,0,0,0,0,0));
        cyc("ba_slot", 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,1,1,1,0));
        cyc("ba_adv",  0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, E(0,0,1,1,1,0));
        cyc("be_a_nt", 0, 0, 4'h0, 1, 4'b0001, 1, 0, 1, 0, E(0,0,0,0,1,0));
        cyc("br_in_annul", 0, 0, 4'h0, 1, 4'b0001, 0, 1, 1, 0,
            E(0,0,1,1,1,1));
        cyc("post_annul", 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,0,0,1,1));
        cyc("be_a_tk", 0, 0, 4'h0, 1, 4'b0001, 1, 1, 1, 0, E(1,0,0,0,1,1));
        cyc("exec_slot", 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,0,1,2,1));
        cyc("dcti",    0, 0, 4'h0, 1, 4'b1001, 0, 0, 1, 0, E(1,0,0,1,2,1));
        cyc("flush_ex", 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, E(0,0,0,1,3,1));
        cyc("post_flush", 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,0,0,3,1));

        // Freeze in SLOT_ANNUL; taken counter already saturated.
        cyc("ba_sat",  0, 0, 4'h0, 1, 4'b1000, 1, 0, 1, 0, E(1,0,0,0,3,1));
        cyc("frz1",    0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,1,1,3,1));
        cyc("frz2",    0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,1,1,3,1));
        cyc("frz3",    0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,1,1,3,1));
        cyc("frz_adv", 0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, E(0,0,1,1,3,1));
        cyc("frz_idle", 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,0,0,3,1));

        // Flag hazard on set0.
        cyc("hz", 1, 0, 4'b0100, 1, 4'b0001, 0, 0, 1, 0,
            E(BYP, !BYP, 0, 0, 3, 1));
        cyc("hz_next", 0, 0, 4'h0, 1, 4'b0001, 0, 0, 1, 0,
            E(1, 0, 0, BYP, 3, 1));
        cyc("hz_slot", 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,0,1,3,1));
        cyc("flush_acc", 0, 0, 4'h0, 1, 4'b1001, 0, 1, 1, 1,
            E(0,0,0,1,3,1));
        cyc("post_fa", 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,0,0,3,2));
        cyc("no_hz", 1, 1, 4'b0000, 1, 4'b0001, 0, 0, 0, 0,
            E(1,0,0,0,3,2));

        // Async reset in the middle of an executed slot.
        cyc("ba_exec", 0, 0, 4'h0, 1, 4'b1000, 0, 0, 1, 0, E(1,0,0,0,3,2));
        cyc("in_exec", 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,0,1,3,2));
        @(posedge clk);
        #1;
        pipe_advance = 1'b0;
        rst_n = 1'b0;
        #1;
        e.name = "async_rst";
        e.v = E(0,0,0,0,0,0);
        q.push_back(e);
        -> chk_ev;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rst2_be0", 0, 0, 4'h0, 1, 4'b0001, 0, 0, 0, 0, E(0,0,0,0,0,0));

        // Five accepted taken branches saturate a 2-bit counter.
        cyc("sat1", 0, 0, 4'h0, 1, 4'b1000, 0, 0, 1, 0, E(1,0,0,0,0,0));
        cyc("sat2", 0, 0, 4'h0, 1, 4'b1000, 0, 0, 1, 0, E(1,0,0,1,1,0));
        cyc("sat3", 0, 0, 4'h0, 1, 4'b1000, 0, 0, 1, 0, E(1,0,0,1,2,0));
        cyc("sat4", 0, 0, 4'h0, 1, 4'b1000, 0, 0, 1, 0, E(1,0,0,1,3,0));
        cyc("sat5", 0, 0, 4'h0, 1, 4'b1000, 0, 0, 1, 0, E(1,0,0,1,3,0));
        cyc("sat_end", 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, E(0,0,0,1,3,0));

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
